// File: rtl/cfar_pkg.sv
// cfar_pkg: shared sizes, sequencer states and the detection report record for the CFAR frame sequencer
package cfar_pkg;
  localparam int INPUT_WIDTH = 16;
  localparam int N_SAMPLES = 512;
  localparam int ADDR_WIDTH = $clog2(N_SAMPLES);
  localparam int IDX_WIDTH = 10;
  localparam int REF_WIN = 16;
  localparam int GUARD_WIN = 2;
  localparam int PAD = (REF_WIN + GUARD_WIN) / 2 + 1;
  localparam int DRAIN = 4;
  localparam int FIFO_DEPTH = 8;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_FLUSH, S_DRAIN, S_DONE} seq_state_e;
  typedef struct packed {
    logic [7:0]             frame;
    logic [IDX_WIDTH-1:0]   index;
    logic [INPUT_WIDTH-1:0] value;
  } det_rpt_t;
endpackage

// File: rtl/cfar_frame_sequencer_if.sv
// cfar_frame_sequencer_if: control, sample memory, detector and report signals of the frame sequencer
interface cfar_frame_sequencer_if;
  import cfar_pkg::*;
  logic                   start, abort, busy, done;
  logic                   mem_rd_en;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [INPUT_WIDTH-1:0] mem_rd_data;
  logic                   det_reset_n, det_input_valid, det_max_valid;
  logic [INPUT_WIDTH-1:0] det_power_in, det_max_value;
  logic [IDX_WIDTH-1:0]   det_index;
  logic                   rpt_valid, rpt_ready, rpt_overflow;
  logic [7:0]             rpt_frame;
  logic [IDX_WIDTH-1:0]   rpt_index;
  logic [INPUT_WIDTH-1:0] rpt_value;
  modport master (
    input  start, abort, mem_rd_data, det_max_valid, det_index, det_max_value, rpt_ready,
    output busy, done, mem_rd_en, mem_addr, det_reset_n, det_power_in, det_input_valid,
           rpt_valid, rpt_frame, rpt_index, rpt_value, rpt_overflow
  );
  modport slave (
    output start, abort, mem_rd_data, det_max_valid, det_index, det_max_value, rpt_ready,
    input  busy, done, mem_rd_en, mem_addr, det_reset_n, det_power_in, det_input_valid,
           rpt_valid, rpt_frame, rpt_index, rpt_value, rpt_overflow
  );
endinterface

// File: rtl/cfar_det_fifo.sv
// cfar_det_fifo: synchronous FIFO of detection reports; a push into a full FIFO succeeds only alongside a pop
module cfar_det_fifo
  import cfar_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  logic     pop,
  input  det_rpt_t din,
  output det_rpt_t dout,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  det_rpt_t mem_q [FIFO_DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic wr, rd;
  always_comb begin
    empty = wp_q == rp_q;
    full = (wp_q ^ rp_q) == PW'(FIFO_DEPTH);
    rd = pop && !empty;
    wr = push && (!full || rd);
    wp_d = wp_q + PW'(wr);
    rp_d = rp_q + PW'(rd);
    dout = mem_q[rp_q[AW-1:0]];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  always_ff @(posedge clk)
    if (wr) mem_q[wp_q[AW-1:0]] <= din;
endmodule

// File: rtl/cfar_frame_sequencer.sv
// cfar_frame_sequencer: rearms the CFAR detector, streams one profile plus zero pads, drains, and queues tagged reports
module cfar_frame_sequencer
  import cfar_pkg::*;
(
  input logic clk,
  input logic reset,
  cfar_frame_sequencer_if.master bus
);
  seq_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0] tag_q, tag_d;
  logic abort_q, abort_d, iv_q, iv_d, pad_q, pad_d, ovf_q, ovf_d;
  logic busy_q, done_q, rd_en_q, rstn_q;
  logic abort_go, last, push, pop, full, empty;
  det_rpt_t din, head;
  always_comb begin
    abort_go = bus.abort && state_q != S_IDLE;
    last = state_q == S_CLEAR  ? cnt_q == ADDR_WIDTH'(1) :
           state_q == S_STREAM ? cnt_q == ADDR_WIDTH'(N_SAMPLES - 1) :
           state_q == S_FLUSH  ? cnt_q == ADDR_WIDTH'(PAD - 1) :
           state_q == S_DRAIN  ? cnt_q == ADDR_WIDTH'(DRAIN - 1) : 1'b1;
    state_d = abort_go ? S_CLEAR :
              state_q == S_IDLE ? (bus.start && !bus.abort ? S_CLEAR : S_IDLE) :
              !last ? state_q :
              state_q == S_CLEAR  ? (abort_q ? S_IDLE : S_STREAM) :
              state_q == S_STREAM ? S_FLUSH :
              state_q == S_FLUSH  ? S_DRAIN :
              state_q == S_DRAIN  ? S_DONE : S_IDLE;
    // an aborted frame still rearms the detector, then returns to IDLE instead of streaming
    abort_d = abort_go || (abort_q && state_d != S_IDLE);
    cnt_d = (state_d != state_q || abort_go || state_q == S_IDLE) ? '0 : cnt_q + 1'b1;
    tag_d = tag_q + 8'(state_q == S_DONE && !abort_go);
    iv_d = !abort_go && (state_q == S_STREAM || state_q == S_FLUSH);
    pad_d = state_q == S_FLUSH;
    push = bus.det_max_valid && state_q != S_CLEAR;
    pop = bus.rpt_ready && !empty;
    ovf_d = ovf_q || (push && full && !pop);
    din = '{frame: tag_q, index: bus.det_index, value: bus.det_max_value};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      tag_q <= '0;
      abort_q <= 1'b0;
      iv_q <= 1'b0;
      pad_q <= 1'b0;
      ovf_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rd_en_q <= 1'b0;
      rstn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      tag_q <= tag_d;
      abort_q <= abort_d;
      iv_q <= iv_d;
      pad_q <= pad_d;
      ovf_q <= ovf_d;
      busy_q <= state_d != S_IDLE;
      done_q <= state_d == S_DONE;
      rd_en_q <= state_d == S_STREAM;
      rstn_q <= state_d != S_CLEAR;
    end
  cfar_det_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  // read data lands the cycle after the strobe, so the issue stage passes it straight through
  assign bus.det_power_in = (iv_q && !pad_q) ? bus.mem_rd_data : '0;
  assign bus.det_input_valid = iv_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.mem_rd_en = rd_en_q;
  assign bus.mem_addr = rd_en_q ? cnt_q : '0;
  assign bus.det_reset_n = rstn_q;
  assign bus.rpt_valid = !empty;
  assign bus.rpt_frame = head.frame;
  assign bus.rpt_index = head.index;
  assign bus.rpt_value = head.value;
  assign bus.rpt_overflow = ovf_q;
endmodule
